// File: rtl/gray_ptr_decoder.sv
// gray_ptr_decoder: resynchronizes a foreign-domain Gray pointer, decodes it to binary and monitors its progression
// Ports: clk/rst (async, active-high); g Gray pointer in; clr_err clears sticky err;
//        b registered binary pointer; valid pipeline warmed up; step/wrap one-cycle advance pulses;
//        err sticky illegal-change flag; laps wrap count modulo 2^LAP_W
module gray_ptr_decoder #(
  parameter int WIDTH = 3,
  parameter int LAP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] g,
  input  logic             clr_err,
  output logic [WIDTH-1:0] b,
  output logic             valid,
  output logic             step,
  output logic             wrap,
  output logic             err,
  output logic [LAP_W-1:0] laps
);
  typedef enum logic {WARM, RUN} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] s1, s2, n, d;
  logic [1:0] wc;
  logic chk, stp, wrp, bad;
  always_comb begin
    for (int i = 0; i < WIDTH; i++) n[i] = ^(s2 >> i);
    d = n - b;
    chk = state == RUN;
    stp = chk && d == WIDTH'(1);
    wrp = stp && n == '0;
    bad = chk && d > WIDTH'(1);
    state_nx = (state == WARM && wc == 2'd2) ? RUN : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      b <= '0;
      wc <= '0;
      state <= WARM;
      step <= 1'b0;
      wrap <= 1'b0;
      err <= 1'b0;
      laps <= '0;
    end else begin
      s1 <= g;
      s2 <= s1;
      b <= n;
      wc <= wc + 2'(wc != 2'd2);
      state <= state_nx;
      step <= stp;
      wrap <= wrp;
      err <= bad | (err & ~clr_err);
      laps <= laps + LAP_W'(wrp);
    end
  end
  assign valid = state == RUN;
endmodule

// File: tb/tb_gray_ptr_decoder.sv
// tb_gray_ptr_decoder: table-driven and sequence checks of gray_ptr_decoder (WIDTH=3, LAP_W=8)
module tb_gray_ptr_decoder;
  logic clk = 1'b0, rst = 1'b1, clr_err = 1'b0;
  logic [2:0] g = '0, b;
  logic valid, step, wrap, err;
  logic [7:0] laps;
  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic [2:0] g;
    logic       clr;
    logic [2:0] b;
    logic       v, s, w, e;
    logic [7:0] l;
  } vec_t;
  vec_t tbl[$];

  gray_ptr_decoder #(.WIDTH(3), .LAP_W(8)) dut (
    .clk(clk), .rst(rst), .g(g), .clr_err(clr_err),
    .b(b), .valid(valid), .step(step), .wrap(wrap), .err(err), .laps(laps)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [2:0] to_gray(input int v);
    logic [2:0] x;
    x = 3'(v);
    return x ^ (x >> 1);
  endfunction

  task automatic add(input logic [2:0] gi, input logic c, input logic [2:0] be,
                     input logic v, input logic s, input logic w, input logic e, input logic [7:0] l);
    vec_t r;
    r.g = gi; r.clr = c; r.b = be; r.v = v; r.s = s; r.w = w; r.e = e; r.l = l;
    tbl.push_back(r);
  endtask

  initial begin
    int steps, wraps;
    int seq[14] = '{7, 0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 5};
    // warm-up, full sequence, wrap
    add(3'b000, 0, 0, 0, 0, 0, 0, 0);
    add(3'b000, 0, 0, 0, 0, 0, 0, 0);
    add(3'b000, 0, 0, 1, 0, 0, 0, 0);
    add(3'b000, 0, 0, 1, 0, 0, 0, 0);
    add(3'b001, 0, 0, 1, 0, 0, 0, 0);
    add(3'b011, 0, 0, 1, 0, 0, 0, 0);
    add(3'b010, 0, 1, 1, 1, 0, 0, 0);
    add(3'b110, 0, 2, 1, 1, 0, 0, 0);
    add(3'b111, 0, 3, 1, 1, 0, 0, 0);
    add(3'b101, 0, 4, 1, 1, 0, 0, 0);
    add(3'b100, 0, 5, 1, 1, 0, 0, 0);
    add(3'b000, 0, 6, 1, 1, 0, 0, 0);
    add(3'b000, 0, 7, 1, 1, 0, 0, 0);
    add(3'b000, 0, 0, 1, 1, 1, 0, 1);
    add(3'b000, 0, 0, 1, 0, 0, 0, 1);
    // illegal jump 2 -> 4, sticky err, clear
    add(3'b001, 0, 0, 1, 0, 0, 0, 1);
    add(3'b011, 0, 0, 1, 0, 0, 0, 1);
    add(3'b110, 0, 1, 1, 1, 0, 0, 1);
    add(3'b110, 0, 2, 1, 1, 0, 0, 1);
    add(3'b110, 0, 4, 1, 0, 0, 1, 1);
    add(3'b110, 0, 4, 1, 0, 0, 1, 1);
    add(3'b110, 0, 4, 1, 0, 0, 1, 1);
    add(3'b110, 1, 4, 1, 0, 0, 0, 1);
    // backward 4 -> 3 sets err, then skip 4 -> 6 on the clr_err edge keeps it
    add(3'b010, 0, 4, 1, 0, 0, 0, 1);
    add(3'b110, 0, 4, 1, 0, 0, 0, 1);
    add(3'b110, 0, 3, 1, 0, 0, 1, 1);
    add(3'b101, 0, 4, 1, 1, 0, 1, 1);
    add(3'b101, 0, 4, 1, 0, 0, 1, 1);
    add(3'b101, 1, 6, 1, 0, 0, 1, 1);
    add(3'b101, 0, 6, 1, 0, 0, 1, 1);

    tick();
    rst = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      g = tbl[i].g;
      clr_err = tbl[i].clr;
      tick();
      chk($sformatf("row%0d b", i), int'(b), int'(tbl[i].b));
      chk($sformatf("row%0d valid", i), int'(valid), int'(tbl[i].v));
      chk($sformatf("row%0d step", i), int'(step), int'(tbl[i].s));
      chk($sformatf("row%0d wrap", i), int'(wrap), int'(tbl[i].w));
      chk($sformatf("row%0d err", i), int'(err), int'(tbl[i].e));
      chk($sformatf("row%0d laps", i), int'(laps), int'(tbl[i].l));
    end

    // clear err with g held, then 256 full laps bring laps back to 1
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr err", int'(err), 0);
    steps = 0;
    wraps = 0;
    for (int k = 1; k <= 2051; k++) begin
      if (k <= 2048) g = to_gray(6 + k);
      tick();
      steps += int'(step);
      wraps += int'(wrap);
      if (wrap && !step) chk("wrap without step", 1, 0);
    end
    chk("lap steps", steps, 2048);
    chk("lap wraps", wraps, 256);
    chk("lap laps", int'(laps), 1);
    chk("lap err", int'(err), 0);
    chk("lap b", int'(b), 6);

    // reach b=5, laps=3, err=1 then async reset between edges
    foreach (seq[i]) begin
      g = to_gray(seq[i]);
      tick();
    end
    tick();
    tick();
    chk("pre-rst b", int'(b), 5);
    chk("pre-rst laps", int'(laps), 3);
    chk("pre-rst err", int'(err), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst b", int'(b), 0);
    chk("async rst valid", int'(valid), 0);
    chk("async rst step", int'(step), 0);
    chk("async rst wrap", int'(wrap), 0);
    chk("async rst err", int'(err), 0);
    chk("async rst laps", int'(laps), 0);
    #1;
    rst = 1'b0;
    tick();
    chk("rewarm e1 valid", int'(valid), 0);
    tick();
    chk("rewarm e2 valid", int'(valid), 0);
    chk("rewarm e2 b", int'(b), 0);
    tick();
    chk("rewarm e3 valid", int'(valid), 1);
    chk("rewarm e3 b", int'(b), 5);
    tick();
    chk("rewarm e4 step", int'(step), 0);
    chk("rewarm e4 err", int'(err), 0);
    chk("rewarm e4 laps", int'(laps), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
